lorenz_step_ctrl: RTL and testbench

- Sequencer for the fixed-point 7.20 Lorenz solver (three Euler integrators, X/Y/Z).
- Decides when the integrators advance: free-run at a programmable rate, single-step, pause, or reload of initial conditions.
- Snapshots the X/Y/Z state after each step and hands it to the downstream plot/draw logic over a valid/ready handshake.
- Stalls stepping while a sample is unaccepted, so no state is skipped.

---
 rtl/lorenz_step_ctrl.sv | 178 +++++++++++++++++
 tb/tb_lorenz_step_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lorenz_step_ctrl.sv
// Step sequencer for the 7.20 Lorenz Euler integrators (X/Y/Z).
// Optional decimation of captured samples under LORENZ_STEP_DECIM_EN.
module lorenz_step_ctrl #(
  parameter int DW    = 27,
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             single,
  input  logic             reinit,
  input  logic [DIV_W-1:0] div,
`ifdef LORENZ_STEP_DECIM_EN
  input  logic [7:0]       decim,
`endif
  input  logic [DW-1:0]    state_x,
  input  logic [DW-1:0]    state_y,
  input  logic [DW-1:0]    state_z,
  output logic             int_en,
  output logic             int_init,
  output logic [DW-1:0]    smp_x,
  output logic [DW-1:0]    smp_y,
  output logic [DW-1:0]    smp_z,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic [CNT_W-1:0] step_count,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_STEP,
    S_CAPT,
    S_HOLD
  } st_t;

  st_t              st_q, st_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             cap;
  logic [DW-1:0]    sx_q, sy_q, sz_q;
`ifdef LORENZ_STEP_DECIM_EN
  logic [7:0]       dcnt_q, dcnt_d;
`endif

  // Next-state and datapath control
  always_comb begin
    st_d  = st_q;
    div_d = div_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    cap   = 1'b0;
`ifdef LORENZ_STEP_DECIM_EN
    dcnt_d = dcnt_q;
`endif
    case (st_q)
      S_INIT: begin
        st_d  = S_IDLE;
        cnt_d = '0;
        vld_d = 1'b0;
        div_d = '0;
`ifdef LORENZ_STEP_DECIM_EN
        dcnt_d = '0;
`endif
      end
      S_IDLE: begin
        if (single) begin
          st_d = S_STEP;
        end else if (run) begin
          st_d  = S_WAIT;
          div_d = div;
        end
      end
      S_WAIT: begin
        if (!run) begin
          st_d = S_IDLE;
        end else if (div_q == '0) begin
          st_d = S_STEP;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_STEP: begin
        cnt_d = cnt_q + CNT_W'(1);
        st_d  = S_CAPT;
`ifdef LORENZ_STEP_DECIM_EN
        if (dcnt_q == decim) begin
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
          if (run) begin
            st_d  = S_WAIT;
            div_d = div;
          end else begin
            st_d = S_IDLE;
          end
        end
`endif
      end
      S_CAPT: begin
        cap   = 1'b1;
        vld_d = 1'b1;
        st_d  = S_HOLD;
      end
      S_HOLD: begin
        if (vld_q && smp_ready) begin
          vld_d = 1'b0;
          if (run) begin
            st_d  = S_WAIT;
            div_d = div;
          end else begin
            st_d = S_IDLE;
          end
        end
      end
      default: st_d = S_INIT;
    endcase
    if (reinit) begin
      st_d  = S_INIT;
      vld_d = 1'b0;
      cnt_d = '0;
      div_d = '0;
`ifdef LORENZ_STEP_DECIM_EN
      dcnt_d = '0;
`endif
    end
  end

  // State, divider, step counter and valid flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= S_INIT;
      div_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

`ifdef LORENZ_STEP_DECIM_EN
  // Decimation counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dcnt_q <= '0;
    else        dcnt_q <= dcnt_d;
  end
`endif

  // Sample snapshot of post-step integrator state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sx_q <= '0;
      sy_q <= '0;
      sz_q <= '0;
    end else if (cap) begin
      sx_q <= state_x;
      sy_q <= state_y;
      sz_q <= state_z;
    end
  end

  assign int_en     = (st_q == S_STEP);
  assign int_init   = (st_q == S_INIT);
  assign busy       = (st_q != S_IDLE);
  assign smp_valid  = vld_q;
  assign smp_x      = sx_q;
  assign smp_y      = sy_q;
  assign smp_z      = sz_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_lorenz_step_ctrl.sv
// Scoreboard bench for lorenz_step_ctrl with a toy integrator model.
// Decimation checks build only with LORENZ_STEP_DECIM_EN.
module tb_lorenz_step_ctrl;
  localparam int DW    = 27;
  localparam int DIV_W = 16;
  localparam int CNT_W = 32;

  logic             clk, reset, run, single, reinit, smp_ready;
  logic [DIV_W-1:0] div;
  logic [DW-1:0]    mx, my, mz;
  logic             int_en, int_init, smp_valid, busy;
  logic [DW-1:0]    smp_x, smp_y, smp_z;
  logic [CNT_W-1:0] step_count;
`ifdef LORENZ_STEP_DECIM_EN
  logic [7:0]       decim;
`endif

  lorenz_step_ctrl #(.DW(DW), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .single(single),
    .reinit(reinit), .div(div),
`ifdef LORENZ_STEP_DECIM_EN
    .decim(decim),
`endif
    .state_x(mx), .state_y(my), .state_z(mz),
    .int_en(int_en), .int_init(int_init),
    .smp_x(smp_x), .smp_y(smp_y), .smp_z(smp_z),
    .smp_valid(smp_valid), .smp_ready(smp_ready),
    .step_count(step_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  int nstep = 0;
  always @(posedge clk) begin
    if (int_init) begin
      mx <= 27'h0100000;
      my <= 27'h0200000;
      mz <= 27'h7f00000;
      nstep <= 0;
    end else if (int_en) begin
      mx <= mx + DW'(32'h1357 + nstep * 3);
      my <= my - DW'(32'h0a11);
      mz <= mz + (mx >> 4);
      nstep <= nstep + 1;
    end
  end

  typedef struct packed {
    logic [DW-1:0] x, y, z;
  } smp_t;

  smp_t sb[$];
  smp_t e;
  int   en_t[$];
  int   hs_t[$];
  int   cyc = 0;
  logic en_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    chk("en_init_excl", 64'(int_en & int_init), 0);
    if (int_init) begin
      sb.delete();
    end else if (en_d) begin
      sb.push_back('{x: mx, y: my, z: mz});
    end
    en_d = int_en;
    if (int_en) en_t.push_back(cyc);
    if (smp_valid && smp_ready) begin
      hs_t.push_back(cyc);
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("smp_x", smp_x, e.x);
        chk("smp_y", smp_y, e.y);
        chk("smp_z", smp_z, e.z);
      end
    end
  end

  task automatic wcyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reinit();
    reinit = 1'b1;
    wcyc(1);
    reinit = 1'b0;
    wcyc(3);
  endtask

  task automatic pulse_single();
    single = 1'b1;
    wcyc(1);
    single = 1'b0;
  endtask

  int   base, hb;
  smp_t hold_exp;
  logic timeout;

  initial begin
    reset = 1'b0; run = 1'b0; single = 1'b0; reinit = 1'b0;
    div = '0; smp_ready = 1'b1;
`ifdef LORENZ_STEP_DECIM_EN
    decim = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_int_init", int_init, 1);
    chk("rst_int_en", int_en, 0);
    chk("rst_valid", smp_valid, 0);
    chk("rst_count", step_count, 0);
    chk("rst_smp_x", smp_x, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    chk("init_cycle", int_init, 1);
    @(negedge clk); #1;
    chk("idle_init", int_init, 0);
    chk("idle_busy", busy, 0);

    // free-run, div=5
    wcyc(0);
    @(posedge clk); #1;
    div = 16'd5; run = 1'b1;
    base = en_t.size();
    wcyc(40);
    run = 1'b0;
    wcyc(10);
    chk("fr_pulses", en_t.size() - base, 4);
    if (en_t.size() - base == 4)
      for (int i = 0; i < 3; i++)
        chk("fr_period", en_t[base+i+1] - en_t[base+i], 9);
    chk("fr_count", step_count, 4);
    chk("fr_busy", busy, 0);
    chk("fr_sb_empty", sb.size(), 0);

    // backpressure, div=0
    div = 16'd0; smp_ready = 1'b0; run = 1'b1;
    base = en_t.size();
    wcyc(10);
    chk("bp_valid_a", smp_valid, 1);
    if (sb.size() > 0) chk("bp_x_a", smp_x, sb[0].x);
    wcyc(10);
    chk("bp_one_en", en_t.size() - base, 1);
    chk("bp_valid_b", smp_valid, 1);
    if (sb.size() > 0) begin
      chk("bp_x_b", smp_x, sb[0].x);
      chk("bp_y_b", smp_y, sb[0].y);
      chk("bp_z_b", smp_z, sb[0].z);
    end
    hb = hs_t.size();
    smp_ready = 1'b1;
    wcyc(2);
    chk("bp_drop", smp_valid, 0);
    wcyc(4);
    chk("bp_seen", 64'(en_t.size() > base + 1 && hs_t.size() > hb), 1);
    if (en_t.size() > base + 1 && hs_t.size() > hb)
      chk("bp_gap", en_t[base+1] - hs_t[hb], 2);
    run = 1'b0;
    wcyc(10);
    chk("bp_busy", busy, 0);

    // single step, second single in HOLD ignored
    pulse_reinit();
    chk("ss_count0", step_count, 0);
    smp_ready = 1'b0;
    base = en_t.size();
    pulse_single();
    wcyc(3);
    pulse_single();
    wcyc(4);
    chk("ss_one_en", en_t.size() - base, 1);
    chk("ss_valid", smp_valid, 1);
    chk("ss_count1", step_count, 1);
    smp_ready = 1'b1;
    wcyc(3);
    chk("ss_drop", smp_valid, 0);
    chk("ss_idle", busy, 0);
    chk("ss_still_one", en_t.size() - base, 1);
    chk("ss_count_end", step_count, 1);

    // reinit while holding a sample
    smp_ready = 1'b0;
    pulse_single();
    wcyc(4);
    chk("ri_valid", smp_valid, 1);
    hold_exp = (sb.size() > 0) ? sb[0] : '0;
    base = en_t.size();
    reinit = 1'b1;
    @(posedge clk); #1;
    reinit = 1'b0;
    @(negedge clk); #1;
    chk("ri_valid0", smp_valid, 0);
    chk("ri_init", int_init, 1);
    chk("ri_count0", step_count, 0);
    chk("ri_smp_keep", smp_x, hold_exp.x);
    smp_ready = 1'b1;
    wcyc(5);
    chk("ri_no_en", en_t.size() - base, 0);
    chk("ri_idle", busy, 0);
    chk("ri_init_off", int_init, 0);

`ifdef LORENZ_STEP_DECIM_EN
    pulse_reinit();
    decim = 8'd3; div = 16'd1; smp_ready = 1'b1; run = 1'b1;
    base = en_t.size();
    hb = hs_t.size();
    timeout = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wcyc(1);
      if (en_t.size() - base >= 12) begin
        timeout = 1'b0;
        break;
      end
    end
    run = 1'b0;
    wcyc(10);
    chk("dc_timeout", timeout, 0);
    chk("dc_steps", en_t.size() - base, 12);
    chk("dc_samples", hs_t.size() - hb, 3);
    chk("dc_count", step_count, 12);
    if (hs_t.size() - hb == 3 && en_t.size() - base == 12)
      for (int k = 0; k < 3; k++)
        chk("dc_which", hs_t[hb+k] - en_t[base+4*k+3], 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
